dummy_accelerator_pipelined_cu: RTL

- Control unit for the next-generation dummy accelerator.
- Accepts up to DEPTH overlapping operations, each with its own programmable latency.
- Returns results strictly in issue order, each with its tag.
- Sits between the core's issue interface and the accelerator datapath; drives slot-write, head-select and bypass controls for a DEPTH-entry result buffer held in the datapath.

---
 rtl/dummy_accelerator_pipelined_cu.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dummy_accelerator_pipelined_cu.sv
// In-order completion control unit: DEPTH-slot circular result buffer with per-op countdown and a zero-latency bypass.
// Optional perf counters are enabled by defining DUMMY_ACC_PIPE_PERF_CNT_EN.
module dummy_accelerator_pipelined_cu #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAT_W = 4,
  parameter int unsigned TAG_W = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [LAT_W-1:0]         lat_i,
  input  logic [TAG_W-1:0]         tag_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [TAG_W-1:0]         tag_o,
  output logic                     alloc_en_o,
  output logic [$clog2(DEPTH)-1:0] alloc_idx_o,
  output logic [$clog2(DEPTH)-1:0] head_idx_o,
  output logic                     bypass_sel_o,
  output logic                     busy_o
`ifdef DUMMY_ACC_PIPE_PERF_CNT_EN
  ,
  output logic [31:0]              perf_ops_o,
  output logic [31:0]              perf_stall_o
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ACTIVE,
    ST_FULL
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_occ;
  logic [CNT_W-1:0] w_occ_nxt;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [TAG_W-1:0] r_tag [DEPTH];
  logic [LAT_W-1:0] r_cnt [DEPTH];

  logic             w_accept;
  logic             w_bypass;
  logic             w_alloc;
  logic             w_head_done;
  logic             w_retire;
  logic [LAT_W-1:0] w_cnt_init;

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    w_head_done  = (r_state != ST_EMPTY) && (r_cnt[r_rd_ptr] == '0);
    ready_o      = (r_state != ST_FULL) && !flush_i;
    w_accept     = valid_i && ready_o;
    w_bypass     = w_accept && (lat_i == '0) && (r_state == ST_EMPTY) && ready_i;
    w_alloc      = w_accept && !w_bypass;
    valid_o      = !flush_i && (w_head_done || w_bypass);
    w_retire     = !flush_i && w_head_done && ready_i;
    bypass_sel_o = w_bypass;
    tag_o        = '0;
    if (w_head_done) begin
      tag_o = r_tag[r_rd_ptr];
    end else if (w_bypass) begin
      tag_o = tag_i;
    end
    alloc_en_o   = w_alloc;
    alloc_idx_o  = r_wr_ptr;
    head_idx_o   = r_rd_ptr;
    busy_o       = (r_state != ST_EMPTY);
    // Stored count is lat-1 so a slot reads done (0) in cycle t+L after its accept cycle t.
    w_cnt_init   = (lat_i == '0) ? '0 : lat_i - LAT_W'(1);
  end

  always_comb begin
    w_occ_nxt = r_occ;
    if (flush_i) begin
      w_occ_nxt = '0;
    end else if (w_alloc && !w_retire) begin
      w_occ_nxt = r_occ + CNT_W'(1);
    end else if (!w_alloc && w_retire) begin
      w_occ_nxt = r_occ - CNT_W'(1);
    end
    w_state_nxt = ST_ACTIVE;
    if (w_occ_nxt == '0) begin
      w_state_nxt = ST_EMPTY;
    end else if (w_occ_nxt == CNT_W'(DEPTH)) begin
      w_state_nxt = ST_FULL;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_EMPTY;
      r_occ   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_occ   <= w_occ_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_tag[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_tag[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - LAT_W'(1);
        end
      end
      if (w_alloc) begin
        r_tag[r_wr_ptr] <= tag_i;
        r_cnt[r_wr_ptr] <= w_cnt_init;
        r_wr_ptr        <= f_inc(r_wr_ptr);
      end
      if (w_retire) begin
        r_rd_ptr <= f_inc(r_rd_ptr);
      end
    end
  end

`ifdef DUMMY_ACC_PIPE_PERF_CNT_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_stall;

  // Saturating; deliberately untouched by flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_ops   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (valid_o && ready_i && (r_perf_ops != '1)) begin
        r_perf_ops <= r_perf_ops + 32'd1;
      end
      if (valid_o && !ready_i && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_ops_o   = r_perf_ops;
  assign perf_stall_o = r_perf_stall;
`endif

endmodule
